// File: rtl/timer_ctrl.sv
// Control stage for a countdown timer: owns the period register, issues load pulses
// and watches the returned count for expiry (one-shot / periodic, sticky irq, missed count).
module timer_ctrl #(
  parameter int unsigned W  = 8,
  parameter int unsigned MW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [W-1:0]  period,
  input  logic          wr_period,
  input  logic          periodic,
  input  logic          start,
  input  logic          stop,
  input  logic          ack,
  input  logic [W-1:0]  tm_count,
  output logic [W-1:0]  tm_value,
  output logic          tm_put,
  output logic          running,
  output logic          irq,
  output logic [MW-1:0] missed
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StRun  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  period_q;
  logic          mode_q, mode_d;
  logic [W-1:0]  value_q, value_d;
  logic          put_q, put_d;
  logic          running_q, running_d;
  logic          irq_q, irq_d;
  logic [MW-1:0] missed_q, missed_d;

  logic [W-1:0]  eff_period;
  logic          do_start;
  logic          expire;

  // A period written in the same cycle as a load is the one that gets loaded.
  assign eff_period = wr_period ? period : period_q;
  assign do_start   = start && (eff_period != '0);
  assign expire     = (state_q == StRun) && (tm_count == '0) && !stop && !do_start;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    value_d = value_q;
    put_d   = 1'b0;
    if (stop) begin
      state_d = StIdle;
      put_d   = 1'b1;
      value_d = '0;
    end else if (do_start) begin
      state_d = StLoad;
      mode_d  = periodic;
      put_d   = 1'b1;
      value_d = eff_period;
    end else begin
      case (state_q)
        StIdle: state_d = StIdle;
        StLoad: state_d = StRun;
        StRun: begin
          if (tm_count == '0) begin
            // A zero period would reload an already-expired count, so stop instead.
            if (mode_q && (eff_period != '0)) begin
              state_d = StLoad;
              put_d   = 1'b1;
              value_d = eff_period;
            end else begin
              state_d = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
    running_d = (state_d != StIdle);
  end

  always_comb begin
    irq_d    = irq_q;
    missed_d = missed_q;
    if (expire) begin
      irq_d = 1'b1;
      if (irq_q && !ack && (missed_q != {MW{1'b1}})) begin
        missed_d = missed_q + MW'(1);
      end
    end else if (ack) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      period_q  <= '0;
      mode_q    <= 1'b0;
      value_q   <= '0;
      put_q     <= 1'b0;
      running_q <= 1'b0;
      irq_q     <= 1'b0;
      missed_q  <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      value_q   <= value_d;
      put_q     <= put_d;
      running_q <= running_d;
      irq_q     <= irq_d;
      missed_q  <= missed_d;
      if (wr_period) begin
        period_q <= period;
      end
    end
  end

  assign tm_value = value_q;
  assign tm_put   = put_q;
  assign running  = running_q;
  assign irq      = irq_q;
  assign missed   = missed_q;

endmodule
